// File: rtl/uart_transmitter.sv
// UART transmitter: 8N1/8N2 framing, LSB first; even parity bit when UART_TX_PARITY_EN is defined.
// Start bit leaves 2 cycles after an idle transfer; one-entry holding register gives back-to-back frames.
module uart_transmitter #(
    parameter int CLKS_PER_BIT = 87,
    parameter int STOP_BITS    = 1
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_tx_dv,
    input  logic [7:0] i_tx_byte,
    output logic       o_tx_ready,
    output logic       o_tx_serial,
    output logic       o_tx_active,
    output logic       o_tx_done
);
    localparam int            CW       = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic          TWO_STOP = (STOP_BITS == 2);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic          stop_idx_q, stop_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    hold_q, hold_d;
    logic          hold_vld_q, hold_vld_d;
    logic          serial_q, serial_d;
    logic          active_q, active_d;
    logic          end_q, end_d;
    logic          done_q, done_d;
    logic          take;
    logic          bit_end;
`ifdef UART_TX_PARITY_EN
    logic          parity_q, parity_d;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_idx_d  = bit_idx_q;
        stop_idx_d = stop_idx_q;
        shift_d    = shift_q;
        hold_d     = hold_q;
        hold_vld_d = hold_vld_q;
        end_d      = 1'b0;
        take       = 1'b0;
        bit_end    = (cnt_q == CNT_LAST);
`ifdef UART_TX_PARITY_EN
        parity_d   = parity_q;
`endif
        if (state_q != IDLE) begin
            cnt_d = bit_end ? '0 : cnt_q + CW'(1);
        end
        case (state_q)
            IDLE: begin
                if (hold_vld_q) begin
                    take    = 1'b1;
                    state_d = START;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d   = DATA;
                    bit_idx_d = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        stop_idx_d = 1'b0;
`ifdef UART_TX_PARITY_EN
                        state_d    = PARITY;
`else
                        state_d    = STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_d    = STOP;
                    stop_idx_d = 1'b0;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    if (TWO_STOP && !stop_idx_q) begin
                        stop_idx_d = 1'b1;
                    end else begin
                        end_d = 1'b1;
                        // A queued byte chains straight into the next start bit.
                        if (hold_vld_q) begin
                            take    = 1'b1;
                            state_d = START;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (take) begin
            shift_d    = hold_q;
            hold_vld_d = 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_d   = ^hold_q;
`endif
        end
        if (i_tx_dv && !hold_vld_q) begin
            hold_d     = i_tx_byte;
            hold_vld_d = 1'b1;
        end

        // Line outputs follow the state register by one cycle.
        case (state_q)
            START:   serial_d = 1'b0;
            DATA:    serial_d = shift_q[bit_idx_q];
`ifdef UART_TX_PARITY_EN
            PARITY:  serial_d = parity_q;
`endif
            default: serial_d = 1'b1;
        endcase
        active_d = (state_q != IDLE);
        done_d   = end_q;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            shift_q    <= '0;
            hold_q     <= '0;
            hold_vld_q <= 1'b0;
            serial_q   <= 1'b1;
            active_q   <= 1'b0;
            end_q      <= 1'b0;
            done_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            stop_idx_q <= stop_idx_d;
            shift_q    <= shift_d;
            hold_q     <= hold_d;
            hold_vld_q <= hold_vld_d;
            serial_q   <= serial_d;
            active_q   <= active_d;
            end_q      <= end_d;
            done_q     <= done_d;
`ifdef UART_TX_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    assign o_tx_ready  = !hold_vld_q;
    assign o_tx_serial = serial_q;
    assign o_tx_active = active_q;
    assign o_tx_done   = done_q;
endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: two instances (1 and 2 stop bits) at 4 clocks per bit, each watched by a
// loopback receiver that pops expected bytes from a scoreboard queue.
module tb_uart_transmitter;
    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int NB0 = 10 + PB;
    localparam int NB1 = 11 + PB;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] dv;
    logic [7:0] byt0, byt1;
    wire  [1:0] rdy, ser, act, don;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int rst_cnt = 0;
    int nfr[2];
    int last_start[2];
    int prev_start[2];
    int last_done[2];
    int prev_done[2];
    int dcnt[2];
    logic [15:0] last_bits[2];
    logic [7:0] q0[$];
    logic [7:0] q1[$];

    uart_transmitter #(.CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_tx_dv(dv[0]), .i_tx_byte(byt0),
        .o_tx_ready(rdy[0]), .o_tx_serial(ser[0]), .o_tx_active(act[0]), .o_tx_done(don[0]));

    uart_transmitter #(.CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_tx_dv(dv[1]), .i_tx_byte(byt1),
        .o_tx_ready(rdy[1]), .o_tx_serial(ser[1]), .o_tx_active(act[1]), .o_tx_done(don[1]));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (don[d] === 1'b1) begin
                prev_done[d] = last_done[d];
                last_done[d] = cyc;
                dcnt[d]      = dcnt[d] + 1;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic chk(input bit ok, input string nm, input int a, input int e);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, a, e);
        end
    endtask

    function automatic logic [15:0] mkframe(input logic [7:0] b, input int nb);
        logic [15:0] f;
        f = '0;
        f[8:1] = b;
`ifdef UART_TX_PARITY_EN
        f[9] = ^b;
`endif
        for (int i = 9 + PB; i < nb; i++) f[i] = 1'b1;
        return f;
    endfunction

    task automatic monitor(input int d, input int nb);
        logic s [0:63];
        logic [15:0] fb, efb;
        logic [7:0] ex;
        int flen, st, rs;
        bit pend, bad_act, bad_done, bad_hold, have;
        flen = nb * CPB;
        pend = 1'b0;
        forever begin
            if (!pend) @(negedge clk);
            pend = 1'b0;
            if (rst_n === 1'b1 && ser[d] === 1'b0) begin
                rs = rst_cnt;
                st = cyc;
                bad_act = 1'b0;
                bad_done = 1'b0;
                bad_hold = 1'b0;
                for (int i = 0; i < flen; i++) begin
                    if (i > 0) @(negedge clk);
                    s[i] = ser[d];
                    if (act[d] !== 1'b1) bad_act = 1'b1;
                    if (i > 0 && don[d] !== 1'b0) bad_done = 1'b1;
                end
                @(negedge clk);
                if (rst_cnt != rs) continue;
                prev_start[d] = last_start[d];
                last_start[d] = st;
                chk(don[d] === 1'b1, "done_after_frame", don[d], 1);
                chk(act[d] === (ser[d] === 1'b0), "active_after_frame", act[d], ser[d] === 1'b0);
                chk(!bad_act, "active_in_frame", bad_act, 0);
                chk(!bad_done, "done_quiet_in_frame", bad_done, 0);
                fb = '0;
                for (int i = 0; i < flen; i++)
                    if (s[i] !== s[(i / CPB) * CPB]) bad_hold = 1'b1;
                for (int b = 0; b < nb; b++) fb[b] = s[b * CPB + CPB / 2];
                chk(!bad_hold, "bit_hold_time", bad_hold, 0);
                last_bits[d] = fb;
                have = (d == 0) ? (q0.size() > 0) : (q1.size() > 0);
                if (!have) begin
                    chk(1'b0, "unexpected_frame", fb, 0);
                end else begin
                    ex = (d == 0) ? q0.pop_front() : q1.pop_front();
                    efb = mkframe(ex, nb);
                    chk(fb[8:1] == ex, "rx_byte", fb[8:1], ex);
                    chk(fb == efb, "frame_bits", fb, efb);
                end
                nfr[d] = nfr[d] + 1;
                pend = (ser[d] === 1'b0);
            end
        end
    endtask

    initial monitor(0, NB0);
    initial monitor(1, NB1);

    task automatic send(input int d, input logic [7:0] b, input bit track, output int te);
        int n;
        n = 0;
        @(negedge clk);
        dv[d] = 1'b1;
        if (d == 0) byt0 = b; else byt1 = b;
        while (rdy[d] !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        te = cyc;
        dv[d] = 1'b0;
        if (n >= 2000) chk(1'b0, "send_timeout", n, 0);
        if (track) begin
            if (d == 0) q0.push_back(b); else q1.push_back(b);
        end
    endtask

    task automatic wait_frames(input int d, input int target, input string nm);
        int n;
        n = 0;
        while (nfr[d] < target && n < 1000) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk(nfr[d] >= target, nm, nfr[d], target);
    endtask

    initial begin
        int te, base, d0, st, n, k;
        logic [7:0] v [0:2];
        logic r;
        rst_n = 1'b0;
        dv = '0;
        byt0 = '0;
        byt1 = '0;
        for (int d = 0; d < 2; d++) begin
            nfr[d] = 0; dcnt[d] = 0; last_start[d] = 0; prev_start[d] = 0;
            last_done[d] = 0; prev_done[d] = 0; last_bits[d] = '0;
        end
        repeat (3) @(negedge clk);
        chk(ser[0] === 1'b1, "rst_serial", ser[0], 1);
        chk(rdy[0] === 1'b1, "rst_ready", rdy[0], 1);
        chk(act[0] === 1'b0, "rst_active", act[0], 0);
        chk(don[0] === 1'b0, "rst_done", don[0], 0);
        chk(ser[1] === 1'b1, "rst_serial2", ser[1], 1);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1: single frame from idle
        d0 = dcnt[0];
        send(0, 8'hA5, 1'b1, te);
        wait_frames(0, 1, "t1_frame");
        chk(last_start[0] - te == 2, "t1_start_latency", last_start[0] - te, 2);
        chk(last_done[0] - last_start[0] == NB0 * CPB, "t1_done_time", last_done[0] - last_start[0], NB0 * CPB);
        chk(dcnt[0] - d0 == 1, "t1_done_count", dcnt[0] - d0, 1);
`ifndef UART_TX_PARITY_EN
        chk(last_bits[0][9:0] == 10'b1101001010, "t1_line_seq", last_bits[0][9:0], 10'b1101001010);
`endif
        repeat (5) @(negedge clk);

        // 2: back-to-back frames
        base = nfr[0];
        send(0, 8'h3C, 1'b1, te);
        chk(rdy[0] === 1'b0, "t2_ready_low", rdy[0], 0);
        @(negedge clk);
        chk(rdy[0] === 1'b1, "t2_ready_after_take", rdy[0], 1);
        repeat (12) @(negedge clk);
        send(0, 8'hC3, 1'b1, te);
        repeat (5) @(negedge clk);
        chk(rdy[0] === 1'b0, "t2_hold_full", rdy[0], 0);
        wait_frames(0, base + 2, "t2_frames");
        chk(last_start[0] - prev_start[0] == NB0 * CPB, "t2_gap", last_start[0] - prev_start[0], NB0 * CPB);
        chk(last_done[0] - prev_done[0] == NB0 * CPB, "t2_done_spacing", last_done[0] - prev_done[0], NB0 * CPB);
        repeat (5) @(negedge clk);

        // 3: valid held high across three bytes
        base = nfr[0];
        v[0] = 8'h00; v[1] = 8'hFF; v[2] = 8'h55;
        k = 0;
        n = 0;
        @(negedge clk);
        dv[0] = 1'b1;
        byt0 = v[0];
        while (k < 3 && n < 3000) begin
            r = rdy[0];
            @(negedge clk);
            n++;
            if (r) begin
                q0.push_back(v[k]);
                k++;
                if (k < 3) byt0 = v[k];
            end
        end
        dv[0] = 1'b0;
        wait_frames(0, base + 3, "t3_frames");
        repeat (20) @(negedge clk);
        chk(nfr[0] == base + 3, "t3_frame_count", nfr[0], base + 3);

        // 4: two stop bits
        send(1, 8'h80, 1'b1, te);
        wait_frames(1, 1, "t4_frame");
        chk(last_done[1] - last_start[1] == NB1 * CPB, "t4_frame_len", last_done[1] - last_start[1], NB1 * CPB);
        chk(last_bits[1][NB1-1] && last_bits[1][NB1-2], "t4_stop_high", last_bits[1][NB1-1:NB1-2], 3);

        // 5: reset during data bit 3 with a byte queued
        base = nfr[0];
        send(0, 8'h96, 1'b0, te);
        send(0, 8'h11, 1'b0, te);
        n = 0;
        while (ser[0] !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (17) @(negedge clk);
        chk(rdy[0] === 1'b0, "t5_queued", rdy[0], 0);
        d0 = dcnt[0];
        rst_cnt++;
        rst_n = 1'b0;
        #1;
        chk(ser[0] === 1'b1, "t5_async_serial", ser[0], 1);
        chk(rdy[0] === 1'b1, "t5_ready", rdy[0], 1);
        chk(act[0] === 1'b0, "t5_active", act[0], 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        chk(dcnt[0] == d0, "t5_no_done", dcnt[0], d0);
        chk(nfr[0] == base, "t5_no_frame", nfr[0], base);
        send(0, 8'h5A, 1'b1, te);
        wait_frames(0, base + 1, "t5_clean_frame");
        chk(last_start[0] - te == 2, "t5_start_latency", last_start[0] - te, 2);

`ifdef UART_TX_PARITY_EN
        // 6: parity bit values and frame length
        base = nfr[0];
        send(0, 8'h01, 1'b1, te);
        wait_frames(0, base + 1, "t6_frame1");
        chk(last_bits[0][9] == 1'b1, "t6_parity_01", last_bits[0][9], 1);
        chk(last_done[0] - last_start[0] == 44, "t6_len1", last_done[0] - last_start[0], 44);
        send(0, 8'hA5, 1'b1, te);
        wait_frames(0, base + 2, "t6_frame2");
        chk(last_bits[0][9] == 1'b0, "t6_parity_a5", last_bits[0][9], 0);
        chk(last_done[0] - last_start[0] == 44, "t6_len2", last_done[0] - last_start[0], 44);
`endif

        repeat (10) @(negedge clk);
        chk(q0.size() == 0, "scoreboard0_empty", q0.size(), 0);
        chk(q1.size() == 0, "scoreboard1_empty", q1.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
